// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset and lock sequencer with staged domain reset release.
//
// Pulses the PLL reset, waits for lock with a per-attempt timeout, requires a
// run of consecutive locked cycles, then releases the sclk-domain reset
// followed (GAP_CYC cycles later) by the pclk-domain reset. Lock loss after
// release or a lock timeout counts as a failed attempt and restarts the
// sequence. i_restart restarts from scratch and clears the attempt count.
//
// Ports:
//   i_clk         reference clock, sole clock of the block
//   i_rst_n       asynchronous active-low reset
//   i_lock        PLL lock, asynchronous to i_clk (synchronized internally)
//   i_restart     single-cycle request to restart the full sequence
//   o_pll_rst     active-high PLL reset
//   o_rst_sclk_n  active-low sclk-domain reset request
//   o_rst_pclk_n  active-low pclk-domain reset request
//   o_ready       high while the sequence is complete (RUN)
//   o_fault       high in FAULT (retry-limit build only, else tied 0)
//   o_retries     failed-attempt count, saturating at 15
//
// Build option: define PLL_RST_SEQ_RETRY_LIMIT_EN to enter FAULT once the
// attempt count reaches MAX_RETRY. Without it FAULT is unreachable and
// MAX_RETRY has no effect.

module pll_rst_seq #(
  parameter int unsigned RST_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned STABLE_CYC  = 1024,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_lock,
  input  logic       i_restart,
  output logic       o_pll_rst,
  output logic       o_rst_sclk_n,
  output logic       o_rst_pclk_n,
  output logic       o_ready,
  output logic       o_fault,
  output logic [3:0] o_retries
);

  // Counter only has to reach the largest terminal count minus one.
  localparam int unsigned Max1   = (RST_CYC > TIMEOUT_CYC) ? RST_CYC : TIMEOUT_CYC;
  localparam int unsigned Max2   = (STABLE_CYC > GAP_CYC) ? STABLE_CYC : GAP_CYC;
  localparam int unsigned CntMax = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelS,
    StRelP,
    StRun,
    StFault
  } state_e;

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
  localparam bit FaultEn = 1'b1;
`else
  localparam bit FaultEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        retries_q, retries_d;
  logic [3:0]        retry_inc;
  logic              lock_meta_q, lock_s;
  logic              bump;
  logic              limit_hit;
  state_e            fail_dest;
  logic              pll_rst_q, sclk_n_q, pclk_n_q, ready_q;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_q <= i_lock;
      lock_s      <= lock_meta_q;
    end
  end

  always_comb begin
    retry_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;
    limit_hit = FaultEn && (retry_inc == 4'(MAX_RETRY));
    fail_dest = limit_hit ? StFault : StPllRst;
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    bump      = 1'b0;
    if (i_restart) begin
      // Restart wins over any simultaneous timeout or lock loss.
      state_d   = StPllRst;
      retries_d = 4'd0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == CntW'(RST_CYC - 1)) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            bump = 1'b1;
          end
        end
        StStable: begin
          // A dropout is not a failed attempt: re-wait with a fresh timeout.
          if (!lock_s) begin
            state_d = StWaitLock;
          end else if (cnt_q == CntW'(STABLE_CYC - 1)) begin
            state_d = StRelS;
          end
        end
        StRelS: begin
          if (!lock_s) begin
            bump = 1'b1;
          end else if (cnt_q == CntW'(GAP_CYC - 1)) begin
            state_d = StRelP;
          end
        end
        StRelP: begin
          if (!lock_s) begin
            bump = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!lock_s) bump = 1'b1;
        end
        StFault: ;
        default: state_d = StPllRst;
      endcase
      if (bump) begin
        state_d   = fail_dest;
        retries_d = retry_inc;
      end
    end
  end

  // Counter restarts on every state entry, including a restart into PLL_RST.
  always_comb begin
    if (i_restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      retries_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pll_rst_q <= 1'b1;
      sclk_n_q  <= 1'b0;
      pclk_n_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      pll_rst_q <= (state_d == StPllRst) || (state_d == StFault);
      sclk_n_q  <= (state_d == StRelS) || (state_d == StRelP) || (state_d == StRun);
      pclk_n_q  <= (state_d == StRelP) || (state_d == StRun);
      ready_q   <= (state_d == StRun);
    end
  end

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
  logic fault_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == StFault);
    end
  end

  assign o_fault = fault_q;
`else
  assign o_fault = 1'b0;
`endif

  assign o_pll_rst    = pll_rst_q;
  assign o_rst_sclk_n = sclk_n_q;
  assign o_rst_pclk_n = pclk_n_q;
  assign o_ready      = ready_q;
  assign o_retries    = retries_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small timing parameters.
// Expectations follow the build option PLL_RST_SEQ_RETRY_LIMIT_EN.

module tb_pll_rst_seq;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_lock;
  logic       i_restart;
  logic       o_pll_rst;
  logic       o_rst_sclk_n;
  logic       o_rst_pclk_n;
  logic       o_ready;
  logic       o_fault;
  logic [3:0] o_retries;

  int n_total = 0;
  int n_bad   = 0;

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  pll_rst_seq #(
    .RST_CYC     (4),
    .TIMEOUT_CYC (100),
    .STABLE_CYC  (20),
    .GAP_CYC     (3),
    .MAX_RETRY   (2)
  ) u_dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_lock       (i_lock),
    .i_restart    (i_restart),
    .o_pll_rst    (o_pll_rst),
    .o_rst_sclk_n (o_rst_sclk_n),
    .o_rst_pclk_n (o_rst_pclk_n),
    .o_ready      (o_ready),
    .o_fault      (o_fault),
    .o_retries    (o_retries)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges; sample/drive 1 ns after each edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_lock    = 1'b0;
    i_restart = 1'b0;

    // Reset state
    ticks(3);
    check_eq("rst_pll_rst", o_pll_rst, 1);
    check_eq("rst_sclk", o_rst_sclk_n, 0);
    check_eq("rst_pclk", o_rst_pclk_n, 0);
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_fault", o_fault, 0);
    check_eq("rst_retries", o_retries, 0);

    // Nominal: full RST_CYC pulse, lock at cycle 10, staged release
    i_rst_n = 1'b1;
    ticks(3);
    check_eq("nom_pll_rst_hold", o_pll_rst, 1);
    ticks(1);
    check_eq("nom_pll_rst_low", o_pll_rst, 0);
    ticks(6);
    i_lock = 1'b1;
    ticks(22);
    check_eq("nom_sclk_early", o_rst_sclk_n, 0);
    ticks(1);
    check_eq("nom_sclk_rise", o_rst_sclk_n, 1);
    check_eq("nom_pclk_after_sclk", o_rst_pclk_n, 0);
    ticks(2);
    check_eq("nom_pclk_early", o_rst_pclk_n, 0);
    ticks(1);
    check_eq("nom_pclk_rise", o_rst_pclk_n, 1);
    check_eq("nom_ready_early", o_ready, 0);
    ticks(1);
    check_eq("nom_ready", o_ready, 1);
    check_eq("nom_retries", o_retries, 0);
    check_eq("nom_pll_rst", o_pll_rst, 0);

    // Lock loss in RUN
    i_lock = 1'b0;
    ticks(2);
    check_eq("loss_ready_sync", o_ready, 1);
    ticks(1);
    check_eq("loss_ready", o_ready, 0);
    check_eq("loss_sclk", o_rst_sclk_n, 0);
    check_eq("loss_pclk", o_rst_pclk_n, 0);
    check_eq("loss_pll_rst", o_pll_rst, 1);
    check_eq("loss_retries", o_retries, 1);

    // Restart clears retries
    i_restart = 1'b1;
    ticks(1);
    i_restart = 1'b0;
    check_eq("rs_retries", o_retries, 0);
    check_eq("rs_pll_rst", o_pll_rst, 1);

    // Glitch in STABLE at stable count 15
    i_lock = 1'b1;
    ticks(18);
    i_lock = 1'b0;
    ticks(1);
    i_lock = 1'b1;
    ticks(7);
    check_eq("gl_no_release", o_rst_sclk_n, 0);
    ticks(15);
    check_eq("gl_sclk_early", o_rst_sclk_n, 0);
    ticks(1);
    check_eq("gl_sclk_rise", o_rst_sclk_n, 1);
    check_eq("gl_retries", o_retries, 0);
    ticks(4);
    check_eq("gl_ready", o_ready, 1);

    // Timeout: lock held low, restart first so the count starts at 0
    i_lock    = 1'b0;
    i_restart = 1'b1;
    ticks(1);
    i_restart = 1'b0;
    check_eq("to_start_retries", o_retries, 0);
    ticks(103);
    check_eq("to1_pll_rst_low", o_pll_rst, 0);
    ticks(1);
    check_eq("to1_pll_rst", o_pll_rst, 1);
    check_eq("to1_retries", o_retries, 1);
    ticks(3);
    check_eq("to1_pulse_hold", o_pll_rst, 1);
    ticks(1);
    check_eq("to1_pulse_end", o_pll_rst, 0);
    ticks(99);
    check_eq("to2_pll_rst_low", o_pll_rst, 0);
    ticks(1);
    check_eq("to2_pll_rst", o_pll_rst, 1);
    check_eq("to2_retries", o_retries, 2);
    check_eq("to2_fault", o_fault, LimitEn ? 1 : 0);
    ticks(3);
    check_eq("to2_pulse_hold", o_pll_rst, 1);
    ticks(1);
    check_eq("to2_after_pulse", o_pll_rst, LimitEn ? 1 : 0);
    check_eq("to2_fault_hold", o_fault, LimitEn ? 1 : 0);
`ifndef PLL_RST_SEQ_RETRY_LIMIT_EN
    ticks(99);
    check_eq("to3_pll_rst_low", o_pll_rst, 0);
    ticks(1);
    check_eq("to3_pll_rst", o_pll_rst, 1);
    check_eq("to3_retries", o_retries, 3);
`endif

    // Restart (from FAULT in the limited build)
    i_restart = 1'b1;
    ticks(1);
    i_restart = 1'b0;
    check_eq("rsf_retries", o_retries, 0);
    check_eq("rsf_fault", o_fault, 0);
    check_eq("rsf_pll_rst", o_pll_rst, 1);

    // Restart coincident with timeout
    ticks(103);
    i_restart = 1'b1;
    ticks(1);
    i_restart = 1'b0;
    check_eq("rst_to_retries", o_retries, 0);
    check_eq("rst_to_fault", o_fault, 0);
    check_eq("rst_to_pll_rst", o_pll_rst, 1);
    ticks(3);
    check_eq("rst_to_hold", o_pll_rst, 1);
    ticks(1);
    check_eq("rst_to_end", o_pll_rst, 0);

    // Async reset mid-REL_S
    i_lock = 1'b1;
    ticks(23);
    check_eq("ar_sclk", o_rst_sclk_n, 1);
    check_eq("ar_pclk", o_rst_pclk_n, 0);
    ticks(1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_eq("ar_pll_rst", o_pll_rst, 1);
    check_eq("ar_sclk_low", o_rst_sclk_n, 0);
    check_eq("ar_pclk_low", o_rst_pclk_n, 0);
    check_eq("ar_ready", o_ready, 0);
    check_eq("ar_fault", o_fault, 0);
    check_eq("ar_retries", o_retries, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
